// File: rtl/access_pkg.sv
// Shared encodings for the access-control initiator: status frames, request codes
// and the requester state machine.
package access_pkg;

    localparam logic [2:0] ST_NONE  = 3'b000;
    localparam logic [2:0] ST_GRANT = 3'b001;
    localparam logic [2:0] ST_DENY  = 3'b010;
    localparam logic [2:0] ST_LOCK  = 3'b100;

    localparam logic [1:0] RQ_NONE   = 2'b00;
    localparam logic [1:0] RQ_VERIFY = 2'b01;
    localparam logic [1:0] RQ_CHANGE = 2'b10;
    localparam logic [1:0] RQ_LOCK   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_LOCK
    } state_t;

    // An op of 00 from the keypad is a plain verify.
    function automatic logic [1:0] map_request(input logic [1:0] op_in);
        return (op_in == RQ_NONE) ? RQ_VERIFY : op_in;
    endfunction

    function automatic logic is_decimal(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/access_requester_down_timer.sv
// Loadable saturating countdown; done is high while the count sits at zero.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; the count stops at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/access_requester.sv
// Keypad front end for the access-control block: collects a 4-digit code, issues
// load/request, waits for the status frame and enforces lockout after repeated denials.
module access_requester
    import access_pkg::*;
#(
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 64,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        clear,
    input  logic [1:0]  op,
    input  logic        ack,
    input  logic [2:0]  status_frame,
    output logic [15:0] code_out,
    output logic        data_load,
    output logic [1:0]  request,
    output logic        granted,
    output logic        denied,
    output logic        timeout,
    output logic        locked_out,
    output logic [2:0]  digit_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);
    localparam int LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int FL_W = $clog2(MAX_FAIL + 1);

    // Timers are preloaded with N-1 so done marks the last of N cycles.
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT - 1);
    localparam logic [LK_W-1:0] LK_LOAD  = LK_W'(LOCK_CYCLES - 1);
    localparam logic [LD_W-1:0] LD_LAST  = LD_W'(LOAD_CYCLES - 1);
    localparam logic [FL_W-1:0] FAIL_MAX = FL_W'(MAX_FAIL);

    state_t          state, state_n;
    logic [15:0]     code_n;
    logic [2:0]      count_n;
    logic [1:0]      op_q, op_n;
    logic            granted_n, denied_n, timeout_n;
    logic [FL_W-1:0] fail_cnt, fail_n;
    logic [LD_W-1:0] load_cnt, load_cnt_n;
    logic            wait_done, lock_done;

    down_timer #(.WIDTH(TO_W)) u_timeout_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (state != S_WAIT),
        .load_value (TO_LOAD),
        .enable     ((state == S_WAIT) && (status_frame == ST_NONE)),
        .done       (wait_done)
    );

    down_timer #(.WIDTH(LK_W)) u_lock_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (state != S_LOCK),
        .load_value (LK_LOAD),
        .enable     (state == S_LOCK),
        .done       (lock_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            code_out    <= '0;
            digit_count <= '0;
            op_q        <= RQ_NONE;
            granted     <= 1'b0;
            denied      <= 1'b0;
            timeout     <= 1'b0;
            fail_cnt    <= '0;
            load_cnt    <= '0;
        end else begin
            state       <= state_n;
            code_out    <= code_n;
            digit_count <= count_n;
            op_q        <= op_n;
            granted     <= granted_n;
            denied      <= denied_n;
            timeout     <= timeout_n;
            fail_cnt    <= fail_n;
            load_cnt    <= load_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        code_n     = code_out;
        count_n    = digit_count;
        op_n       = op_q;
        granted_n  = granted;
        denied_n   = denied;
        timeout_n  = timeout;
        fail_n     = fail_cnt;
        load_cnt_n = load_cnt;

        case (state)
            S_IDLE: begin
                if (digit_valid && is_decimal(digit)) begin
                    code_n  = {12'h000, digit};
                    count_n = 3'd1;
                    state_n = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (clear) begin
                    code_n  = '0;
                    count_n = '0;
                    state_n = S_IDLE;
                end else if (digit_valid && is_decimal(digit)) begin
                    code_n  = {code_out[11:0], digit};
                    count_n = digit_count + 3'd1;
                    if (digit_count == 3'd3) begin
                        op_n       = op;
                        load_cnt_n = '0;
                        state_n    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (load_cnt == LD_LAST) begin
                    load_cnt_n = '0;
                    state_n    = S_REQ;
                end else begin
                    load_cnt_n = load_cnt + LD_W'(1);
                end
            end
            S_REQ: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                case (status_frame)
                    ST_NONE: begin
                        if (wait_done) begin
                            timeout_n = 1'b1;
                            state_n   = S_DONE;
                        end
                    end
                    ST_GRANT: begin
                        granted_n = 1'b1;
                        fail_n    = '0;
                        state_n   = S_DONE;
                    end
                    ST_LOCK: begin
                        code_n  = '0;
                        count_n = '0;
                        state_n = S_LOCK;
                    end
                    default: begin
                        // ST_DENY and any unrecognised frame count as a denial.
                        denied_n = 1'b1;
                        if (fail_cnt != FAIL_MAX) begin
                            fail_n = fail_cnt + FL_W'(1);
                        end
                        state_n = S_DONE;
                    end
                endcase
            end
            S_DONE: begin
                if (ack) begin
                    granted_n = 1'b0;
                    denied_n  = 1'b0;
                    timeout_n = 1'b0;
                    code_n    = '0;
                    count_n   = '0;
                    if (fail_cnt >= FAIL_MAX) begin
                        fail_n  = '0;
                        state_n = S_LOCK;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_LOCK: begin
                if (lock_done) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Interface strobes decode straight from the state register so reset drops them at once.
    assign data_load  = (state == S_LOAD);
    assign request    = (state == S_REQ) ? map_request(op_q) : RQ_NONE;
    assign locked_out = (state == S_LOCK);

endmodule

// File: doc/access_requester.md
Name: access_requester

Overview:
- Initiator-side front end for the access-control block.
- Collects four 4-bit keypad digits into a 16-bit code, then drives the code, load strobe and 2-bit request into the access-control block.
- Waits for that block's 3-bit status frame and reports grant, deny or timeout to the user-interface logic.
- Tracks consecutive denials and imposes a timed lockout.

Parameters:
- LOAD_CYCLES, 2, number of cycles data_load is held high with code_out stable (min 1).
- TIMEOUT, 64, cycles to wait in WAIT for a non-zero status frame before declaring timeout.
- MAX_FAIL, 3, consecutive denials that trigger lockout (min 1).
- LOCK_CYCLES, 1000, lockout duration in cycles.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset; sampled on the rising edge of clk.
- digit_valid, input, 1, one-cycle strobe: digit is valid.
- digit, input, 4, keypad digit; values 0-9 accepted, A-F ignored.
- clear, input, 1, discards the partially entered code.
- op, input, 2, operation latched with the 4th digit: 01 verify, 10 change code, 11 lock; 00 is treated as verify.
- ack, input, 1, user acknowledges the result and returns the block to IDLE.
- status_frame, input, 3, from access control: 000 busy/none, 001 granted, 010 denied, 100 locked; any other value is treated as denied.
- code_out, output, 16, assembled code to access control.
- data_load, output, 1, load strobe to access control.
- request, output, 2, request to access control.
- granted, denied, timeout, output, 1 each, result flags; at most one high at a time, held until ack.
- locked_out, output, 1, high during lockout.
- digit_count, output, 3, digits entered so far (0-4).

Behaviour:
- Reset (rst==0 at a clock edge):
  - all outputs go to 0 and the state goes to IDLE;
  - the fail counter and lockout timer clear;
  - reset mid-operation aborts immediately, dropping data_load and request that same edge.
- States: IDLE, COLLECT, LOAD, REQ, WAIT, DONE, LOCK.
- IDLE:
  - A valid digit (0-9) loads code_out = {12'h000, digit}, sets digit_count=1 and moves to COLLECT.
  - A-F digits are ignored.
- COLLECT:
  - Each valid digit shifts in: code_out <= {code_out[11:0], digit}; digit_count increments.
  - On the 4th digit, op is latched and the state moves to LOAD the next cycle.
  - clear returns to IDLE with code_out=0 and digit_count=0.
  - clear and digit_valid in the same cycle: clear wins.
- LOAD:
  - data_load=1 for exactly LOAD_CYCLES cycles; code_out is frozen; digit inputs are ignored.
  - Then go to REQ.
- REQ:
  - request = latched op (00 mapped to 01) for exactly one cycle; data_load=0.
  - Then go to WAIT.
  - request is 00 in every other state.
- WAIT:
  - Status is sampled each cycle starting the cycle after REQ.
  - 001 sets granted, clears the fail counter and goes to DONE.
  - 010 or an unknown value sets denied, increments the fail counter and goes to DONE.
  - 100 sets locked_out and goes to LOCK.
  - If the status stays 000 for TIMEOUT consecutive cycles, set timeout and go to DONE; the fail counter is unchanged.
- DONE:
  - Flags and code_out are held.
  - ack clears the flags, code_out and digit_count, then goes to IDLE.
  - If the fail counter has reached MAX_FAIL at ack, go to LOCK instead of IDLE and reset the counter.
  - Digits are ignored.
- LOCK:
  - locked_out=1; all inputs except rst are ignored.
  - After LOCK_CYCLES cycles, clear locked_out and go to IDLE.
- Counters:
  - The timeout counter is sized clog2(TIMEOUT+1) bits.
  - The lockout counter is sized clog2(LOCK_CYCLES+1) bits.
  - Neither counter wraps; each saturates at its terminal value.
- Latency:
  - 4th digit edge to data_load high: 1 cycle.
  - data_load fall to request pulse: 0 cycles (adjacent).

Decomposition:
- Shared package (access_pkg) holds:
  - status-frame encodings: ST_NONE, ST_GRANT, ST_DENY, ST_LOCK;
  - request encodings: RQ_NONE, RQ_VERIFY, RQ_CHANGE, RQ_LOCK;
  - state enum.
- One natural sub-module, down_timer: a loadable saturating countdown with a done flag, instantiated twice (timeout and lockout).

Test Plan:
- Digits 1,4,7,6, op=01, status 001 two cycles after REQ:
  - code_out=16'h1476;
  - data_load high for 2 cycles, then request=01 for 1 cycle;
  - granted=1 until ack, then IDLE.
- Digits 2,4,5,6, then status 010:
  - denied=1, fail count 1;
  - digit_valid pulses with digit=5 during DONE leave code_out=16'h2456.
- Three consecutive deny cycles, then ack:
  - locked_out=1 for exactly LOCK_CYCLES cycles;
  - digits ignored throughout;
  - IDLE afterwards.
- Status held 000:
  - timeout=1 exactly TIMEOUT cycles after REQ;
  - granted=0 and denied=0.
- Digits 1,2 then clear together with digit_valid:
  - digit_count=0, code_out=0;
  - next digits 9,9,9,9 give code_out=16'h9999.
- rst=0 during LOAD:
  - at the next edge data_load=0, request=00, code_out=0 and all flags 0.
